fft_peak_display: RTL and testbench

- Consumes the frequency-domain sample stream produced by FftBlock in the CLK_25MHZ domain.
- Tracks the strongest bin in each frame and converts that bin to a frequency in Hz.
- Drives the eight 5-bit digit inputs and decimal points of sevensegment: peak frequency on dig7..dig3, peak magnitude on dig2..dig0.

---
 rtl/fpd_pkg.sv | 32 +++
 rtl/fft_peak_display_if.sv | 13 +
 rtl/bin2bcd_seq.sv | 84 ++++++++
 rtl/fft_peak_display.sv | 208 ++++++++++++++++++++
 tb/tb_fft_peak_display.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fpd_pkg.sv
// fpd_pkg: shared types and constants for fft_peak_display.
//   state_t         - controller states
//   BLANK_CODE_DFLT - sevensegment code for a dark digit
//   DP_SEP          - decimal point mask (separator after dig3)
//   bcd_t           - one BCD digit
//   digit_code()    - map a BCD digit to a sevensegment digit code
package fpd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    MULT  = 3'd2,
    CONV  = 3'd3,
    LATCH = 3'd4
  } state_t;

  localparam logic [4:0] BLANK_CODE_DFLT = 5'h10;
  localparam logic [7:0] DP_SEP          = 8'b0000_1000;

  typedef logic [3:0] bcd_t;

  // Blanked digits show the dark code, others the plain BCD value.
  function automatic logic [4:0] digit_code(input bcd_t d, input logic blank,
                                            input logic [4:0] blank_code);
    if (blank) begin
      return blank_code;
    end else begin
      return {1'b0, d};
    end
  endfunction

endpackage

// File: rtl/fft_peak_display_if.sv
// fft_peak_display_if: FftBlock frequency-sample stream.
//   freq_valid - sample strobe (flgFreqSampleValid)
//   freq_addr  - bin address (addrFreq)
//   freq_data  - bin magnitude (byteFreqSample)
// master drives the stream, slave consumes it.
interface fft_peak_display_if;
  logic       freq_valid;
  logic [9:0] freq_addr;
  logic [7:0] freq_data;

  modport master (output freq_valid, freq_addr, freq_data);
  modport slave  (input  freq_valid, freq_addr, freq_data);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter.
//   clk, reset_n - clock, async active-low reset
//   start        - load bin and begin (ignored while busy)
//   bin          - binary input, sampled on start
//   done         - one-cycle pulse WIDTH cycles after start
//   bcd          - NDIG BCD digits, LSD in bits [3:0]; stable until next start
module bin2bcd_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NDIG  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                done,
  output logic [NDIG*4-1:0]   bcd
);

  localparam int unsigned SRW = NDIG * 4 + WIDTH;
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  logic [SRW-1:0] sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
  function automatic logic [SRW-1:0] dabble_step(input logic [SRW-1:0] sr);
    logic [SRW-1:0] t;
    t = sr;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (t[WIDTH + 4*i +: 4] >= 4'd5) begin
        t[WIDTH + 4*i +: 4] = t[WIDTH + 4*i +: 4] + 4'd3;
      end else begin
        t[WIDTH + 4*i +: 4] = t[WIDTH + 4*i +: 4];
      end
    end
    return {t[SRW-2:0], 1'b0};
  endfunction

  // The load cycle also performs the first iteration (digits start at 0, so
  // no adjust is needed), giving exactly WIDTH cycles from start to done.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      sr_d  = dabble_step(sr_q);
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else if (start) begin
      sr_d   = dabble_step({{(NDIG*4){1'b0}}, bin});
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = sr_q[SRW-1:WIDTH];

endmodule

// File: rtl/fft_peak_display.sv
// fft_peak_display: tracks the strongest FFT bin per frame and shows its
// frequency (dig7..dig3) and magnitude (dig2..dig0) on sevensegment.
//   clk, reset_n   - CLK_25MHZ, async active-low reset
//   fft            - frequency-sample stream from FftBlock
//   hold           - 1 freezes the display
//   dig0..dig7     - digit codes, decpts - decimal points (1 = lit)
//   peak_bin/mag   - last latched peak, frame_done - pulse on update
module fft_peak_display
  import fpd_pkg::*;
#(
  parameter int unsigned NUM_BINS   = 512,
  parameter int unsigned MIN_BIN    = 1,
  parameter int unsigned BIN_HZ     = 47,
  parameter int unsigned MAG_THRESH = 8,
  parameter logic [4:0]  BLANK_CODE = BLANK_CODE_DFLT
) (
  input  logic                clk,
  input  logic                reset_n,
  fft_peak_display_if.slave   fft,
  input  logic                hold,
  output logic [4:0]          dig0,
  output logic [4:0]          dig1,
  output logic [4:0]          dig2,
  output logic [4:0]          dig3,
  output logic [4:0]          dig4,
  output logic [4:0]          dig5,
  output logic [4:0]          dig6,
  output logic [4:0]          dig7,
  output logic [7:0]          decpts,
  output logic [8:0]          peak_bin,
  output logic [7:0]          peak_mag,
  output logic                frame_done
);

  // Address 0 doubles as the frame marker, so it must never be eligible.
  if (MIN_BIN < 1) begin : g_min_bin_chk
    $error("fft_peak_display: MIN_BIN must be at least 1");
  end

  state_t          state_q, state_d;
  logic [7:0]      run_mag_q, run_mag_d;
  logic [8:0]      run_bin_q, run_bin_d;
  logic            mag_seen_q, mag_seen_d;
  logic [7:0][4:0] dig_q, dig_d;
  logic [7:0]      decpts_q, decpts_d;
  logic [8:0]      peak_bin_q, peak_bin_d;
  logic [7:0]      peak_mag_q, peak_mag_d;
  logic            frame_done_q, frame_done_d;

  logic            start_s, freq_done_s, mag_done_s;
  logic [15:0]     freq_hz_s;
  logic [19:0]     freq_bcd_s;
  logic [11:0]     mag_bcd_s;
  logic            eligible_s, last_bin_s, below_s;
  logic            fz7_s, fz6_s, fz5_s, fz4_s, mz2_s, mz1_s;

  // The frequency converter captures the product on its start cycle, which
  // registers freq_hz without spending an extra cycle.
  assign freq_hz_s  = 16'({7'd0, run_bin_q} * 16'(BIN_HZ));

  assign eligible_s = ({1'b0, fft.freq_addr} >= 11'(MIN_BIN)) &&
                      ({1'b0, fft.freq_addr} <  11'(NUM_BINS));
  assign last_bin_s = ({1'b0, fft.freq_addr} == 11'(NUM_BINS - 1));
  assign below_s    = ({1'b0, run_mag_q} < 9'(MAG_THRESH));

  // Leading-zero chains, most significant digit first.
  assign fz7_s = (freq_bcd_s[19:16] == 4'd0);
  assign fz6_s = fz7_s && (freq_bcd_s[15:12] == 4'd0);
  assign fz5_s = fz6_s && (freq_bcd_s[11:8]  == 4'd0);
  assign fz4_s = fz5_s && (freq_bcd_s[7:4]   == 4'd0);
  assign mz2_s = (mag_bcd_s[11:8] == 4'd0);
  assign mz1_s = mz2_s && (mag_bcd_s[7:4] == 4'd0);

  bin2bcd_seq #(.WIDTH(16), .NDIG(5)) u_freq_bcd (
    .clk(clk), .reset_n(reset_n), .start(start_s), .bin(freq_hz_s),
    .done(freq_done_s), .bcd(freq_bcd_s)
  );

  bin2bcd_seq #(.WIDTH(8), .NDIG(3)) u_mag_bcd (
    .clk(clk), .reset_n(reset_n), .start(start_s), .bin(run_mag_q),
    .done(mag_done_s), .bcd(mag_bcd_s)
  );

  // Next-state and datapath update for the frame controller.
  always_comb begin
    state_d      = state_q;
    run_mag_d    = run_mag_q;
    run_bin_d    = run_bin_q;
    mag_seen_d   = mag_seen_q;
    dig_d        = dig_q;
    decpts_d     = decpts_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    frame_done_d = 1'b0;
    start_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fft.freq_valid && (fft.freq_addr == 10'd0)) begin
          run_mag_d = 8'd0;
          run_bin_d = 9'd0;
          state_d   = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!fft.freq_valid) begin
          state_d = SCAN;
        end else if (fft.freq_addr == 10'd0) begin
          run_mag_d = 8'd0;
          run_bin_d = 9'd0;
        end else begin
          // Strict compare keeps the lowest bin on ties.
          if (eligible_s && (fft.freq_data > run_mag_q)) begin
            run_mag_d = fft.freq_data;
            run_bin_d = fft.freq_addr[8:0];
          end else begin
            run_mag_d = run_mag_q;
          end
          if (last_bin_s) begin
            state_d = MULT;
          end else begin
            state_d = SCAN;
          end
        end
      end
      MULT: begin
        start_s    = 1'b1;
        mag_seen_d = 1'b0;
        state_d    = CONV;
      end
      CONV: begin
        // The magnitude converter finishes first; remember its pulse.
        if (mag_done_s) begin
          mag_seen_d = 1'b1;
        end else begin
          mag_seen_d = mag_seen_q;
        end
        if (freq_done_s && (mag_seen_q || mag_done_s)) begin
          state_d = LATCH;
        end else begin
          state_d = CONV;
        end
      end
      LATCH: begin
        if (!hold) begin
          peak_bin_d   = run_bin_q;
          peak_mag_d   = run_mag_q;
          decpts_d     = DP_SEP;
          frame_done_d = 1'b1;
          dig_d[7] = digit_code(freq_bcd_s[19:16], below_s || fz7_s, BLANK_CODE);
          dig_d[6] = digit_code(freq_bcd_s[15:12], below_s || fz6_s, BLANK_CODE);
          dig_d[5] = digit_code(freq_bcd_s[11:8],  below_s || fz5_s, BLANK_CODE);
          dig_d[4] = digit_code(freq_bcd_s[7:4],   below_s || fz4_s, BLANK_CODE);
          dig_d[3] = digit_code(freq_bcd_s[3:0],   below_s,          BLANK_CODE);
          dig_d[2] = digit_code(mag_bcd_s[11:8],   mz2_s,            BLANK_CODE);
          dig_d[1] = digit_code(mag_bcd_s[7:4],    mz1_s,            BLANK_CODE);
          dig_d[0] = digit_code(mag_bcd_s[3:0],    1'b0,             BLANK_CODE);
        end else begin
          frame_done_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller, running peak and display registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      run_mag_q    <= 8'd0;
      run_bin_q    <= 9'd0;
      mag_seen_q   <= 1'b0;
      dig_q        <= {8{BLANK_CODE}};
      decpts_q     <= 8'd0;
      peak_bin_q   <= 9'd0;
      peak_mag_q   <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_mag_q    <= run_mag_d;
      run_bin_q    <= run_bin_d;
      mag_seen_q   <= mag_seen_d;
      dig_q        <= dig_d;
      decpts_q     <= decpts_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dig0       = dig_q[0];
  assign dig1       = dig_q[1];
  assign dig2       = dig_q[2];
  assign dig3       = dig_q[3];
  assign dig4       = dig_q[4];
  assign dig5       = dig_q[5];
  assign dig6       = dig_q[6];
  assign dig7       = dig_q[7];
  assign decpts     = decpts_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_peak_display.sv
// tb_fft_peak_display: scoreboard bench for fft_peak_display. Expected peak,
// digits and update cycle are computed from the driven frame and queued; the
// monitor pops one entry per frame_done pulse.
module tb_fft_peak_display;

  typedef struct packed {
    logic [8:0]  bin;
    logic [7:0]  mag;
    logic [39:0] digs;
    logic [31:0] done_cyc;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       hold;
  logic [4:0] dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
  logic [7:0] decpts;
  logic [8:0] peak_bin;
  logic [7:0] peak_mag;
  logic       frame_done;

  fft_peak_display_if fft_bus ();

  fft_peak_display dut (
    .clk(clk), .reset_n(reset_n), .fft(fft_bus.slave), .hold(hold),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dig4(dig4), .dig5(dig5), .dig6(dig6), .dig7(dig7),
    .decpts(decpts), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .frame_done(frame_done)
  );

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         cyc = 0;
  logic [7:0] frame_data [0:511];
  exp_t       sb_q [$];
  exp_t       last_exp;
  exp_t       mon_e;
  logic       prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t calc_exp(input int done_cyc);
    exp_t e;
    int   best_bin, best_mag, freq;
    int   p10 [5] = '{1, 10, 100, 1000, 10000};
    logic [4:0] d [8];
    best_bin = 0;
    best_mag = 0;
    for (int a = 1; a < 512; a++) begin
      if (int'(frame_data[a]) > best_mag) begin
        best_mag = int'(frame_data[a]);
        best_bin = a;
      end
    end
    freq = best_bin * 47;
    for (int i = 0; i < 5; i++)
      d[3+i] = ((i == 0 || freq >= p10[i]) && best_mag >= 8) ? 5'((freq / p10[i]) % 10) : 5'h10;
    for (int i = 0; i < 3; i++)
      d[i] = (i == 0 || best_mag >= p10[i]) ? 5'((best_mag / p10[i]) % 10) : 5'h10;
    e.bin      = 9'(best_bin);
    e.mag      = 8'(best_mag);
    e.digs     = {d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0]};
    e.done_cyc = 32'(done_cyc);
    return e;
  endfunction

  function automatic logic [39:0] obs_digs();
    return {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};
  endfunction

  task automatic clear_frame();
    for (int a = 0; a < 512; a++) frame_data[a] = 8'd0;
  endtask

  // Drives addresses 0..last_addr, one per cycle; pushes the expectation when
  // the final bin goes out. release_at >= 0 drops hold at that address.
  task automatic drive_frame(input int last_addr, input bit expect_latch, input int release_at);
    for (int a = 0; a <= last_addr; a++) begin
      @(negedge clk);
      fft_bus.freq_valid = 1'b1;
      fft_bus.freq_addr  = 10'(a);
      fft_bus.freq_data  = frame_data[a];
      if (a == release_at) hold = 1'b0;
      if (a == 511 && expect_latch) sb_q.push_back(calc_exp(cyc + 19));
    end
    @(negedge clk);
    fft_bus.freq_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_digs"}, obs_digs(), {8{5'h10}});
    check_eq({tag, "_decpts"}, decpts, 8'h00);
    check_eq({tag, "_bin"}, peak_bin, 9'd0);
    check_eq({tag, "_mag"}, peak_mag, 8'd0);
    check_eq({tag, "_done"}, frame_done, 1'b0);
  endtask

  // Scoreboard monitor: every frame_done pulse must match a queued frame.
  always @(negedge clk) begin
    if (frame_done) begin
      check_eq("done_width", prev_done, 1'b0);
      check_eq("sb_pending", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("latency", cyc, mon_e.done_cyc);
        check_eq("peak_bin", peak_bin, mon_e.bin);
        check_eq("peak_mag", peak_mag, mon_e.mag);
        check_eq("digits", obs_digs(), mon_e.digs);
        check_eq("decpts", decpts, 8'h08);
        last_exp = mon_e;
      end
    end
    prev_done <= frame_done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n            = 1'b0;
    hold               = 1'b0;
    fft_bus.freq_valid = 1'b0;
    fft_bus.freq_addr  = 10'd0;
    fft_bus.freq_data  = 8'd0;
    last_exp           = '0;
    clear_frame();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Single peak: bin 100 = 200 -> 4700 Hz.
    clear_frame();
    frame_data[100] = 8'd200;
    drive_frame(511, 1'b1, -1);
    repeat (22) @(negedge clk);

    // DC ignored, lowest bin wins a tie.
    clear_frame();
    frame_data[0]  = 8'd255;
    frame_data[30] = 8'd90;
    frame_data[60] = 8'd90;
    drive_frame(511, 1'b1, -1);
    repeat (22) @(negedge clk);

    // Below threshold: frequency blanked.
    for (int a = 0; a < 512; a++) frame_data[a] = 8'd5;
    drive_frame(511, 1'b1, -1);
    repeat (22) @(negedge clk);

    // Hold: no pulse, display unchanged.
    hold = 1'b1;
    clear_frame();
    frame_data[10] = 8'd70;
    drive_frame(511, 1'b0, -1);
    repeat (25) @(negedge clk);
    check_eq("hold_bin", peak_bin, last_exp.bin);
    check_eq("hold_mag", peak_mag, last_exp.mag);
    check_eq("hold_digs", obs_digs(), last_exp.digs);

    // Hold released during CONV; frame starting 5 cycles later is dropped.
    clear_frame();
    frame_data[20] = 8'd120;
    drive_frame(511, 1'b1, -1);
    repeat (3) @(negedge clk);
    clear_frame();
    frame_data[50] = 8'd99;
    drive_frame(511, 1'b0, 3);
    repeat (25) @(negedge clk);
    check_eq("drop_bin", peak_bin, 9'd20);

    // Restart mid-scan.
    clear_frame();
    frame_data[150] = 8'd250;
    drive_frame(200, 1'b0, -1);
    clear_frame();
    frame_data[300] = 8'd40;
    drive_frame(511, 1'b1, -1);
    repeat (22) @(negedge clk);

    // Async reset while in SCAN.
    clear_frame();
    frame_data[40] = 8'd100;
    drive_frame(100, 1'b0, -1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst_scan");
    @(negedge clk);
    reset_n = 1'b1;

    // Async reset while in CONV.
    clear_frame();
    frame_data[7] = 8'd33;
    drive_frame(511, 1'b0, -1);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst_conv");
    @(negedge clk);
    reset_n = 1'b1;

    // Clean frame after reset.
    clear_frame();
    frame_data[255] = 8'd17;
    drive_frame(511, 1'b1, -1);
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("sb_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
